// File: rtl/adv_timer_cntrl_pkg.sv
// Shared types and constants for the multi-channel timer controller.
// Holds the channel state encoding and the status byte bit positions.
package adv_timer_cntrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_RUN       = 2'b01,
    ST_STOP_PEND = 2'b10
  } ch_state_e;

  localparam int unsigned STAT_W         = 8;
  localparam int unsigned STAT_PEND_BIT  = 0;
  localparam int unsigned STAT_DONE_BIT  = 1;
  localparam int unsigned STAT_STATE_LSB = 2;

  // Code reported in status; any unknown encoding reads as IDLE.
  function automatic logic [1:0] state_code(ch_state_e s);
    logic [1:0] c;
    c = 2'b00;
    case (s)
      ST_RUN:       c = 2'b01;
      ST_STOP_PEND: c = 2'b10;
      default:      c = 2'b00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/adv_timer_cntrl_ch.sv
// One timer channel: IDLE/RUN/STOP_PEND FSM, pending and done flags.
// Ports: cfg_* commands, cnt_* counter events, ctrl_* controls, status_o byte.
module adv_timer_cntrl_ch
  import adv_timer_cntrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       cfg_start_i,
  input  logic       cfg_stop_i,
  input  logic       cfg_rst_i,
  input  logic       cfg_update_i,
  input  logic       cfg_arm_i,
  input  logic       cfg_stop_mode_i,
  input  logic       cfg_oneshot_i,
  input  logic       cnt_update_i,
  input  logic       cnt_end_i,
  output logic       ctrl_cnt_upd_o,
  output logic       ctrl_all_upd_o,
  output logic       ctrl_active_o,
  output logic       ctrl_rst_o,
  output logic       ctrl_arm_o,
  output logic       ctrl_done_o,
  output logic [7:0] status_o
);

  ch_state_e state_q, state_d;
  logic      pend_q, pend_d;
  logic      done_q, done_d;
  logic      run_s, pend_s, idle_s;
  logic      launch;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  // Start beats stop beats counter end.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (cfg_start_i)
          state_d = ST_RUN;
        else if (cfg_stop_i)
          state_d = cfg_stop_mode_i ? ST_STOP_PEND : ST_IDLE;
        else if (cnt_end_i && cfg_oneshot_i)
          state_d = ST_IDLE;
      end
      ST_STOP_PEND: begin
        if (cfg_start_i)
          state_d = ST_RUN;
        else if (cfg_stop_i && !cfg_stop_mode_i)
          state_d = ST_IDLE;
        else if (cnt_end_i)
          state_d = ST_IDLE;
      end
      default: begin
        state_d = cfg_start_i ? ST_RUN : ST_IDLE;
      end
    endcase
  end

  always_comb begin
    run_s  = (state_q == ST_RUN);
    pend_s = (state_q == ST_STOP_PEND);
    idle_s = !run_s && !pend_s;
    launch = idle_s && cfg_start_i;

    ctrl_rst_o     = cfg_rst_i    || launch;
    ctrl_cnt_upd_o = cfg_update_i || launch;
    ctrl_all_upd_o = cnt_update_i || launch;
    ctrl_arm_o     = cfg_arm_i;
    ctrl_active_o  = run_s || pend_s;

    ctrl_done_o = 1'b0;
    if (!cfg_start_i) begin
      if (run_s && !cfg_stop_i)
        ctrl_done_o = cnt_end_i && cfg_oneshot_i;
      else if (pend_s && !(cfg_stop_i && !cfg_stop_mode_i))
        ctrl_done_o = cnt_end_i;
    end

    status_o = '0;
    status_o[STAT_STATE_LSB +: 2] = state_code(state_q);
    status_o[STAT_DONE_BIT]       = done_q;
    status_o[STAT_PEND_BIT]       = pend_q;
  end

  // Update request wins over a same-cycle shadow reload.
  always_comb begin
    pend_d = pend_q;
    if (cfg_update_i)
      pend_d = 1'b1;
    else if (cnt_update_i)
      pend_d = 1'b0;

    done_d = done_q;
    if (ctrl_done_o)
      done_d = 1'b1;
    else if (cfg_start_i || cfg_rst_i)
      done_d = 1'b0;
  end

endmodule

// File: rtl/adv_timer_cntrl_mc.sv
// Multi-channel timer controller: N_CH independent channel FSMs.
// Ports: per-channel cfg/cnt inputs, ctrl outputs, packed 8-bit status.
module adv_timer_cntrl_mc
  import adv_timer_cntrl_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [N_CH-1:0]   cfg_start_i,
  input  logic [N_CH-1:0]   cfg_stop_i,
  input  logic [N_CH-1:0]   cfg_rst_i,
  input  logic [N_CH-1:0]   cfg_update_i,
  input  logic [N_CH-1:0]   cfg_arm_i,
  input  logic [N_CH-1:0]   cfg_stop_mode_i,
  input  logic [N_CH-1:0]   cfg_oneshot_i,
  input  logic [N_CH-1:0]   cnt_update_i,
  input  logic [N_CH-1:0]   cnt_end_i,
  output logic [N_CH-1:0]   ctrl_cnt_upd_o,
  output logic [N_CH-1:0]   ctrl_all_upd_o,
  output logic [N_CH-1:0]   ctrl_active_o,
  output logic [N_CH-1:0]   ctrl_rst_o,
  output logic [N_CH-1:0]   ctrl_arm_o,
  output logic [N_CH-1:0]   ctrl_done_o,
  output logic [8*N_CH-1:0] status_o
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    adv_timer_cntrl_ch u_ch (
      .clk_i           (clk_i),
      .rstn_i          (rstn_i),
      .cfg_start_i     (cfg_start_i[c]),
      .cfg_stop_i      (cfg_stop_i[c]),
      .cfg_rst_i       (cfg_rst_i[c]),
      .cfg_update_i    (cfg_update_i[c]),
      .cfg_arm_i       (cfg_arm_i[c]),
      .cfg_stop_mode_i (cfg_stop_mode_i[c]),
      .cfg_oneshot_i   (cfg_oneshot_i[c]),
      .cnt_update_i    (cnt_update_i[c]),
      .cnt_end_i       (cnt_end_i[c]),
      .ctrl_cnt_upd_o  (ctrl_cnt_upd_o[c]),
      .ctrl_all_upd_o  (ctrl_all_upd_o[c]),
      .ctrl_active_o   (ctrl_active_o[c]),
      .ctrl_rst_o      (ctrl_rst_o[c]),
      .ctrl_arm_o      (ctrl_arm_o[c]),
      .ctrl_done_o     (ctrl_done_o[c]),
      .status_o        (status_o[c*STAT_W +: STAT_W])
    );
  end

endmodule

// File: tb/tb_adv_timer_cntrl_mc.sv
// Bench for adv_timer_cntrl_mc: directed stimulus with a queued scoreboard.
// Same-cycle expectations drain mid-cycle, next-cycle ones after the edge.
module tb_adv_timer_cntrl_mc;

  localparam int N = 4;
  localparam int S_STAT = 0;
  localparam int S_RST  = 1;
  localparam int S_CUPD = 2;
  localparam int S_AUPD = 3;
  localparam int S_ACT  = 4;
  localparam int S_DONE = 5;
  localparam int S_ARM  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic [N-1:0] start, stop, crst, upd, arm;
  logic [N-1:0] smode, oneshot, cupd, cend;
  logic [N-1:0] cnt_upd_o, all_upd_o, active_o;
  logic [N-1:0] rst_o, arm_o, done_o;
  logic [8*N-1:0] status;

  adv_timer_cntrl_mc #(.N_CH(N)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .cfg_start_i     (start),
    .cfg_stop_i      (stop),
    .cfg_rst_i       (crst),
    .cfg_update_i    (upd),
    .cfg_arm_i       (arm),
    .cfg_stop_mode_i (smode),
    .cfg_oneshot_i   (oneshot),
    .cnt_update_i    (cupd),
    .cnt_end_i       (cend),
    .ctrl_cnt_upd_o  (cnt_upd_o),
    .ctrl_all_upd_o  (all_upd_o),
    .ctrl_active_o   (active_o),
    .ctrl_rst_o      (rst_o),
    .ctrl_arm_o      (arm_o),
    .ctrl_done_o     (done_o),
    .status_o        (status)
  );

  typedef struct {
    string       tag;
    int          sel;
    int          ch;
    logic [31:0] exp;
  } exp_t;

  exp_t q_now[$];
  exp_t q_nxt[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(int sel, int ch);
    logic [N-1:0] v;
    v = '0;
    case (sel)
      S_STAT: return (ch < 0) ? 32'(status)
                              : 32'(status[8*ch +: 8]);
      S_RST:  v = rst_o;
      S_CUPD: v = cnt_upd_o;
      S_AUPD: v = all_upd_o;
      S_ACT:  v = active_o;
      S_DONE: v = done_o;
      default: v = arm_o;
    endcase
    return (ch < 0) ? 32'(v) : {31'b0, v[ch]};
  endfunction

  task automatic expn(string tag, int sel, int ch,
                      logic [31:0] e);
    exp_t x;
    x.tag = tag; x.sel = sel; x.ch = ch; x.exp = e;
    q_now.push_back(x);
  endtask

  task automatic expx(string tag, int sel, int ch,
                      logic [31:0] e);
    exp_t x;
    x.tag = tag; x.sel = sel; x.ch = ch; x.exp = e;
    q_nxt.push_back(x);
  endtask

  task automatic tick();
    exp_t x;
    #2;
    while (q_now.size() > 0) begin
      x = q_now.pop_front();
      chk(x.tag, obs(x.sel, x.ch), x.exp);
    end
    @(negedge clk);
    while (q_nxt.size() > 0) begin
      x = q_nxt.pop_front();
      chk(x.tag, obs(x.sel, x.ch), x.exp);
    end
    start = '0; stop = '0; crst = '0;
    upd = '0; cupd = '0; cend = '0;
  endtask

  initial begin
    rstn = 1'b0;
    start = '0; stop = '0; crst = '0; upd = '0;
    arm = '0; smode = '0; oneshot = '0;
    cupd = '0; cend = '0;

    crst[2] = 1'b1;
    expn("rst_status", S_STAT, -1, 32'h0);
    expn("rst_active", S_ACT, -1, 32'h0);
    expn("rst_passthru", S_RST, -1, 32'h4);
    expn("rst_cupd", S_CUPD, -1, 32'h0);
    tick();
    rstn = 1'b1;
    expx("post_rst_status", S_STAT, -1, 32'h0);
    tick();

    start[0] = 1'b1;
    expn("c0_start_rst", S_RST, 0, 1);
    expn("c0_start_cupd", S_CUPD, 0, 1);
    expn("c0_start_aupd", S_AUPD, 0, 1);
    expn("c0_act_reg", S_ACT, 0, 0);
    expx("c0_active", S_ACT, 0, 1);
    expx("c0_status", S_STAT, 0, 8'h04);
    tick();
    start[0] = 1'b1;
    expn("c0_restart_ign", S_RST, 0, 0);
    expx("c0_still_run", S_STAT, 0, 8'h04);
    tick();

    start[3] = 1'b1; stop[3] = 1'b1;
    expn("c3_ss_rst", S_RST, -1, 32'h8);
    expx("c3_ss_status", S_STAT, -1, 32'h04000004);
    tick();

    start[1] = 1'b1;
    expx("c1_run", S_STAT, 1, 8'h04);
    tick();
    smode[1] = 1'b1; stop[1] = 1'b1;
    expx("c1_pend0", S_STAT, 1, 8'h08);
    tick();
    for (int i = 1; i < 5; i++) begin
      expn("c1_nodone", S_DONE, 1, 0);
      expx("c1_pend", S_STAT, 1, 8'h08);
      tick();
    end
    cend[1] = 1'b1;
    expn("c1_done", S_DONE, -1, 32'h2);
    expn("c1_pend_last", S_STAT, 1, 8'h08);
    expx("c1_idle_done", S_STAT, 1, 8'h02);
    expx("c1_inactive", S_ACT, 1, 0);
    tick();
    start[1] = 1'b1;
    expx("c1_done_clr", S_STAT, 1, 8'h04);
    tick();
    smode[1] = 1'b0; stop[1] = 1'b1;
    expx("c1_imm_stop", S_STAT, 1, 8'h00);
    tick();

    start[2] = 1'b1;
    expx("c2_run", S_STAT, 2, 8'h04);
    tick();
    cend[2] = 1'b1;
    expn("c2_nos_nodone", S_DONE, 2, 0);
    expx("c2_nos_run", S_STAT, 2, 8'h04);
    tick();
    oneshot[2] = 1'b1; cend[2] = 1'b1;
    expn("c2_os_done", S_DONE, 2, 1);
    expx("c2_os_idle", S_STAT, 2, 8'h02);
    tick();
    cend[2] = 1'b1;
    expn("c2_idle_end", S_DONE, 2, 0);
    expx("c2_idle_keep", S_STAT, 2, 8'h02);
    tick();
    oneshot[2] = 1'b0;

    upd[0] = 1'b1; cupd[0] = 1'b1;
    expn("c0_cupd", S_CUPD, 0, 1);
    expn("c0_aupd", S_AUPD, 0, 1);
    expx("c0_pend_set", S_STAT, 0, 8'h05);
    tick();
    cupd[0] = 1'b1;
    expn("c0_cupd_off", S_CUPD, 0, 0);
    expx("c0_pend_clr", S_STAT, 0, 8'h04);
    tick();

    arm = 4'b1010;
    expn("arm_pass", S_ARM, -1, 32'ha);
    tick();
    arm = '0;

    crst[2] = 1'b1;
    expn("c2_rst_o", S_RST, 2, 1);
    expx("c2_done_rst", S_STAT, 2, 8'h00);
    tick();

    start[1] = 1'b1;
    expx("c1_run2", S_STAT, 1, 8'h04);
    tick();
    smode[1] = 1'b1; stop[1] = 1'b1;
    expx("pre_rst_all", S_STAT, -1, 32'h04000804);
    tick();
    rstn = 1'b0; cend[1] = 1'b1;
    expn("arst_nodone", S_DONE, -1, 32'h0);
    expn("arst_status", S_STAT, -1, 32'h0);
    expn("arst_active", S_ACT, -1, 32'h0);
    tick();
    rstn = 1'b1;
    expx("arst_after", S_STAT, -1, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adv_timer_cntrl_mc.md
ADV_TIMER_CNTRL_MC -- requirements
Module: adv_timer_cntrl_mc

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent timer channels (legal 1..16).
REQ-002 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rstn_i  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports cfg_start_i, cfg_stop_i, cfg_rst_i, cfg_update_i, cfg_arm_i  input  N_CH each  one-cycle per-channel command pulses (arm is level).
REQ-005 SHALL have port cfg_stop_mode_i  input  N_CH  0 = immediate stop, 1 = graceful stop at next counter end.
REQ-006 SHALL have port cfg_oneshot_i  input  N_CH  level; 1 = channel stops itself at counter end.
REQ-007 SHALL have ports cnt_update_i, cnt_end_i  input  N_CH each  counter shadow-reload pulse and counter-end (terminal count) pulse.
REQ-008 SHALL have ports ctrl_cnt_upd_o, ctrl_all_upd_o, ctrl_active_o, ctrl_rst_o, ctrl_arm_o, ctrl_done_o  output  N_CH each  per-channel controls to counter/comparators.
REQ-009 SHALL have port status_o  output  8*N_CH  channel c at bits [8c+7:8c] = {4'h0, state[1:0], done_flag, pending}.

Function
REQ-010 Each channel SHALL run an independent FSM: IDLE (2'b00), RUN (2'b01), STOP_PEND (2'b10); 2'b11 unreachable, decodes to IDLE.
REQ-011 IDLE + cfg_start: next RUN; same cycle ctrl_rst_o, ctrl_cnt_upd_o, ctrl_all_upd_o all asserted (combinational, one cycle).
REQ-012 Outside REQ-011, ctrl_rst_o = cfg_rst_i, ctrl_cnt_upd_o = cfg_update_i, ctrl_all_upd_o = cnt_update_i per channel.
REQ-013 RUN + cfg_start: ignored (no restart pulse); STOP_PEND + cfg_start: back to RUN, no reset pulse.
REQ-014 RUN + cfg_stop, stop_mode 0: next IDLE; stop_mode 1: next STOP_PEND.
REQ-015 STOP_PEND + cnt_end_i: next IDLE, ctrl_done_o pulses same cycle as cnt_end_i.
REQ-016 RUN + cnt_end_i + cfg_oneshot_i: next IDLE, ctrl_done_o pulses same cycle; cnt_end_i without oneshot: stay RUN, no done.
REQ-017 Priority per cycle: start > stop > cnt_end; start with stop simultaneously SHALL resolve as start only.
REQ-018 cnt_end_i in IDLE SHALL be ignored.
REQ-019 ctrl_active_o SHALL be 1 in RUN and STOP_PEND, registered (no combinational path from inputs).
REQ-020 ctrl_arm_o SHALL equal cfg_arm_i combinationally.
REQ-021 pending SHALL set on cfg_update_i, clear on cnt_update_i only when cfg_update_i is low same cycle (set wins).
REQ-022 done_flag SHALL set one cycle after a ctrl_done_o pulse and clear on next cfg_start_i or cfg_rst_i to that channel.
REQ-023 Channels SHALL share no state; command on channel c SHALL never alter outputs of channel d != c.

Reset
REQ-024 On rstn_i low all channels SHALL go IDLE, pending 0, done_flag 0, immediately (asynchronous).
REQ-025 During reset ctrl_active_o and status_o SHALL be 0; combinational outputs follow REQ-012 with state IDLE.
REQ-026 Reset mid-STOP_PEND SHALL drop to IDLE without ctrl_done_o.

Structure
REQ-027 A shared package adv_timer_cntrl_pkg SHALL hold the state enum and status bit-position constants.
REQ-028 Per-channel logic SHALL live in sub-module adv_timer_cntrl_ch, instantiated N_CH times by a generate loop.

Verification
REQ-029 Ch0 IDLE, start pulse -> same cycle rst/cnt_upd/all_upd = 1, next cycle active = 1, status[7:0] = 8'h04.
REQ-030 Ch1 RUN, stop_mode 1 + stop, then cnt_end after 5 cycles -> status state 2'b10 for 5 cycles, done pulse with cnt_end, then IDLE, status[15:8] = 8'h02.
REQ-031 Ch2 RUN, oneshot = 1, cnt_end -> done pulse, IDLE; oneshot = 0 -> stays RUN, no done.
REQ-032 Ch0 cfg_update and cnt_update same cycle -> pending = 1; later cnt_update alone -> pending = 0.
REQ-033 Start and stop same cycle on ch3 from IDLE -> RUN with reset pulse; other channels' outputs unchanged.
REQ-034 rstn_i low while ch1 STOP_PEND -> immediate IDLE, no done, all status_o = 0.
